fft_frame_sequencer: RTL
========================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: sample width W = 2**N bits, matching the FFT stages.
REQ-002 SHALL have parameter LAT, default 3: clock cycles from dp_in presented to dp_out valid, one per registered stage.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream sample valid.
REQ-006 SHALL have port in_data  input  W  upstream sample.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  result sample valid.
REQ-009 SHALL have port out_data  output  W  result sample.
REQ-010 SHALL have port out_last  output  1  marks result index 7.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port dp_in  output  8*W  frame to datapath, x[k] at bits [k*W +: W].
REQ-013 SHALL have port dp_out  input  8*W  datapath result, X[k] at bits [k*W +: W].
REQ-014 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-015 SHALL have port frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-016 SHALL implement states COLLECT, RUN, DRAIN; reset state COLLECT.
REQ-017 COLLECT: in_ready=1; each in_valid&&in_ready writes in_data to ibuf[idx], idx increments; the accept at idx=7 moves to RUN with idx=0.
REQ-018 in_valid gaps SHALL stall COLLECT without losing or duplicating samples.
REQ-019 dp_in SHALL be driven directly from ibuf and stay constant throughout RUN.
REQ-020 RUN: wait counter counts 0..LAT from entry cycle; on the cycle count==LAT, dp_out SHALL be captured into obuf and the state moves to DRAIN; RUN lasts exactly LAT+1 cycles.
REQ-021 in_ready SHALL be 0 in RUN and DRAIN; no sample is accepted outside COLLECT.
REQ-022 DRAIN: out_valid=1, out_data=obuf[idx], out_last=(idx==7); idx increments on out_valid&&out_ready.
REQ-023 When out_ready=0, out_data, out_last and idx SHALL hold stable (no drop, no repeat).
REQ-024 The handshake at idx=7 in DRAIN SHALL increment frame_cnt, clear idx and return to COLLECT; in_ready rises on the next cycle.
REQ-025 Arithmetic: samples pass through unmodified; idx is 3 bits; wait counter is wide enough for LAT (clog2(LAT+1), minimum 1 bit).
REQ-026 out_valid, out_last SHALL be 0 outside DRAIN; out_data SHALL be 0 outside DRAIN.

Reset
REQ-027 rst low SHALL immediately force state COLLECT, idx=0, wait counter=0, ibuf=obuf=0, frame_cnt=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, dp_in=0.
REQ-028 in_ready SHALL rise in the first clock cycle after rst deasserts; reset mid-frame discards that frame entirely.

Structure
REQ-029 A shared package fft_pkg SHALL hold FFT_POINTS=8, the state encoding, and the default LAT.
REQ-030 ibuf and obuf SHALL each be an instance of one sub-module fft_frame_buffer (8 x W registers, indexed write, full-frame parallel load/read, async active-low clear).

Verification (bench wires dp_in/dp_out to the three FFT stages, LAT=3, N=4)
REQ-031 Reset: hold rst low 3 cycles, release -> all outputs 0 during reset, in_ready=1 first cycle after.
REQ-032 Impulse: x=[1,0,0,0,0,0,0,0], out_ready=1 -> RUN lasts 4 cycles, outputs X[0..7]=1, out_last only on 8th, frame_cnt=1.
REQ-033 Constant: x=all 2 -> X[0]=16, X[1..7]=0; in_valid toggled every other cycle during COLLECT -> same result.
REQ-034 Backpressure: out_ready low 5 cycles at idx=3 -> out_data stays X[3], then X[3..7] delivered once each, in order.
REQ-035 Reset mid-DRAIN at idx=4 -> immediate zero outputs, frame_cnt=0; following impulse frame produces correct result.
REQ-036 Back-to-back: 256 frames streamed -> frame_cnt wraps to 0, in_ready never high while busy=1.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg: shared frame geometry, FSM encoding and default datapath latency
// Revision 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_POINTS  = 8;
  localparam int IDX_W       = 3;
  localparam int DEFAULT_LAT = 3;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  // Wait counter must reach LAT; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_buffer: 8 x W register file, indexed write or full-frame load
// Revision 1.0
// ---------------------------------------------------------------------------
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [W-1:0]            wr_data,
  input  logic                    load_en,
  input  logic [FFT_POINTS*W-1:0] load_data,
  output logic [FFT_POINTS*W-1:0] frame
);

  logic [FFT_POINTS*W-1:0] data;

  // A full-frame load takes priority over a single-sample write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (load_en) begin
      data <= load_data;
    end else if (wr_en) begin
      data[wr_idx*W +: W] <= wr_data;
    end
  end

  assign frame = data;

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_sequencer: collects 8 samples, runs the FFT datapath, drains result
// Revision 1.0
// ---------------------------------------------------------------------------
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = DEFAULT_LAT,
  localparam int W  = 2**N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [FFT_POINTS*W-1:0] dp_in,
  input  logic [FFT_POINTS*W-1:0] dp_out,
  output logic                    busy,
  output logic [7:0]              frame_cnt
);

  localparam int            CW    = cnt_width(LAT);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  logic [1:0]              state;
  logic [1:0]              next_state;
  logic [IDX_W-1:0]        idx;
  logic [CW-1:0]           wait_cnt;
  logic [FFT_POINTS*W-1:0] obuf_frame;
  logic                    accept;
  logic                    deliver;
  logic                    last_idx;
  logic                    run_done;

  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign last_idx = (idx == 3'd7);
  assign run_done = (state == ST_RUN) && (wait_cnt == LAT_C);

  always_comb begin
    next_state = state;
    case (state)
      ST_COLLECT: if (accept && last_idx)  next_state = ST_RUN;
      ST_RUN:     if (run_done)            next_state = ST_DRAIN;
      ST_DRAIN:   if (deliver && last_idx) next_state = ST_COLLECT;
      default:                             next_state = ST_COLLECT;
    endcase
  end

  // in_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_COLLECT;
      idx       <= '0;
      wait_cnt  <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == ST_COLLECT);
      if (accept || deliver) begin
        idx <= idx + 1'b1;
      end
      if ((state == ST_RUN) && !run_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (deliver && last_idx) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  fft_frame_buffer #(.W(W)) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_idx    (idx),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .frame     (dp_in)
  );

  fft_frame_buffer #(.W(W)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .load_en   (run_done),
    .load_data (dp_out),
    .frame     (obuf_frame)
  );

  assign out_valid = (state == ST_DRAIN);
  assign out_last  = out_valid && last_idx;
  assign out_data  = out_valid ? obuf_frame[idx*W +: W] : '0;
  assign busy      = (state != ST_COLLECT);

endmodule
`default_nettype wire
